// File: rtl/panel_scan_sequencer.sv
// panel_scan_sequencer: row fetch, PWM compare/shift/latch and brightness reload sequencing for an LED panel
module panel_scan_sequencer #(
  parameter int ROWS      = 16,
  parameter int PWM_STEPS = 256,
  parameter int SHIFT_LEN = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         brightness_req,
  input  logic [383:0] frame_data,
  output logic         mem_rd_en,
  output logic [3:0]   mem_row_addr,
  output logic [383:0] row_colors,
  output logic [3:0]   row_select,
  output logic [7:0]   pwm_time,
  output logic         load_led_vals,
  output logic         load_brightness,
  output logic         shift,
  output logic         panel_latch,
  output logic         frame_done,
  output logic         brightness_ack
);
  localparam int SW = $clog2(SHIFT_LEN + 1);
  localparam logic [3:0]    ROW_MAX   = 4'(ROWS - 1);
  localparam logic [7:0]    PWM_MAX   = 8'(PWM_STEPS - 1);
  localparam logic [SW-1:0] SHIFT_MAX = SW'(SHIFT_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_LOAD, S_SHIFT, S_LATCH, S_NEXT, S_BLOAD, S_BSHIFT, S_BLATCH
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] shift_cnt_q, shift_cnt_d;
  logic [3:0]    row_cnt_q, row_cnt_d;
  logic          pend_q, pend_d;
  logic          mem_rd_en_q, mem_rd_en_d;
  logic [3:0]    mem_row_addr_q, mem_row_addr_d;
  logic [383:0]  row_colors_q, row_colors_d;
  logic [3:0]    row_select_q, row_select_d;
  logic [7:0]    pwm_time_q, pwm_time_d;
  logic          load_led_vals_q, load_led_vals_d;
  logic          load_brightness_q, load_brightness_d;
  logic          shift_q, shift_d;
  logic          panel_latch_q, panel_latch_d;
  logic          frame_done_q, frame_done_d;
  logic          brightness_ack_q, brightness_ack_d;

  // Next-state, counters and sticky brightness request; a request in BLATCH survives the clear
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    row_cnt_d   = row_cnt_q;
    pend_d      = brightness_req | (pend_q & (state_q != S_BLATCH));
    case (state_q)
      S_IDLE:    state_d = enable ? (pend_q ? S_BLOAD : S_FETCH) : S_IDLE;
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_LOAD;
      S_LOAD:    state_d = S_SHIFT;
      S_BLOAD:   state_d = S_BSHIFT;
      S_SHIFT, S_BSHIFT: begin
        shift_cnt_d = (shift_cnt_q == SHIFT_MAX) ? '0 : shift_cnt_q + SW'(1);
        if (shift_cnt_q == SHIFT_MAX) state_d = (state_q == S_SHIFT) ? S_LATCH : S_BLATCH;
      end
      S_LATCH:   state_d = (pwm_time_q == PWM_MAX) ? S_NEXT : S_LOAD;
      S_NEXT: begin
        row_cnt_d = (row_cnt_q == ROW_MAX) ? 4'd0 : row_cnt_q + 4'd1;
        state_d   = !enable ? S_IDLE : ((row_cnt_q == ROW_MAX) && pend_q) ? S_BLOAD : S_FETCH;
      end
      S_BLATCH:  state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the upcoming state so each strobe lines up with its state
  always_comb begin
    mem_rd_en_d       = state_d == S_FETCH;
    mem_row_addr_d    = (state_d == S_FETCH) ? row_cnt_d : mem_row_addr_q;
    row_colors_d      = (state_q == S_CAPTURE) ? frame_data : row_colors_q;
    row_select_d      = (state_q == S_CAPTURE) ? row_cnt_q : row_select_q;
    pwm_time_d        = (state_q == S_CAPTURE) ? 8'd0 :
                        (state_q == S_LATCH && state_d == S_LOAD) ? pwm_time_q + 8'd1 : pwm_time_q;
    load_led_vals_d   = state_d == S_LOAD;
    load_brightness_d = state_d == S_BLOAD;
    shift_d           = (state_d == S_SHIFT) || (state_d == S_BSHIFT);
    panel_latch_d     = (state_d == S_LATCH) || (state_d == S_BLATCH);
    frame_done_d      = (state_d == S_NEXT) && (row_cnt_q == ROW_MAX);
    brightness_ack_d  = state_d == S_BLATCH;
  end

  // State and output registers; reset aborts the scan immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      shift_cnt_q       <= '0;
      row_cnt_q         <= '0;
      pend_q            <= 1'b0;
      mem_rd_en_q       <= 1'b0;
      mem_row_addr_q    <= '0;
      row_colors_q      <= '0;
      row_select_q      <= '0;
      pwm_time_q        <= '0;
      load_led_vals_q   <= 1'b0;
      load_brightness_q <= 1'b0;
      shift_q           <= 1'b0;
      panel_latch_q     <= 1'b0;
      frame_done_q      <= 1'b0;
      brightness_ack_q  <= 1'b0;
    end else begin
      state_q           <= state_d;
      shift_cnt_q       <= shift_cnt_d;
      row_cnt_q         <= row_cnt_d;
      pend_q            <= pend_d;
      mem_rd_en_q       <= mem_rd_en_d;
      mem_row_addr_q    <= mem_row_addr_d;
      row_colors_q      <= row_colors_d;
      row_select_q      <= row_select_d;
      pwm_time_q        <= pwm_time_d;
      load_led_vals_q   <= load_led_vals_d;
      load_brightness_q <= load_brightness_d;
      shift_q           <= shift_d;
      panel_latch_q     <= panel_latch_d;
      frame_done_q      <= frame_done_d;
      brightness_ack_q  <= brightness_ack_d;
    end
  end

  assign mem_rd_en       = mem_rd_en_q;
  assign mem_row_addr    = mem_row_addr_q;
  assign row_colors      = row_colors_q;
  assign row_select      = row_select_q;
  assign pwm_time        = pwm_time_q;
  assign load_led_vals   = load_led_vals_q;
  assign load_brightness = load_brightness_q;
  assign shift           = shift_q;
  assign panel_latch     = panel_latch_q;
  assign frame_done      = frame_done_q;
  assign brightness_ack  = brightness_ack_q;
endmodule

// File: doc/panel_scan_sequencer.md
PANEL_SCAN_SEQUENCER -- requirements
Module: panel_scan_sequencer

Interface
REQ-001 Parameter ROWS, default 16: number of panel rows scanned per frame.
REQ-002 Parameter PWM_STEPS, default 256: number of PWM compare steps per row.
REQ-003 Parameter SHIFT_LEN, default 16: number of shift pulses per serial load.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  1 = run scan; sampled only in IDLE and NEXT.
REQ-007 brightness_req  input  1  one-cycle request to reload brightness at next frame start.
REQ-008 frame_data  input  384  row pixel data from frame memory; valid the cycle after mem_rd_en.
REQ-009 mem_rd_en  output  1  frame memory read strobe.
REQ-010 mem_row_addr  output  4  row index being read.
REQ-011 row_colors  output  384  registered row data to the panel driver.
REQ-012 row_select  output  4  row currently driven on the panel.
REQ-013 pwm_time  output  8  current PWM compare value.
REQ-014 load_led_vals  output  1  one-cycle compare-and-load strobe to the panel driver.
REQ-015 load_brightness  output  1  one-cycle brightness-load strobe to the panel driver.
REQ-016 shift  output  1  shift enable to the panel driver.
REQ-017 panel_latch  output  1  one-cycle output-latch strobe to the LED drivers.
REQ-018 frame_done  output  1  one-cycle pulse at end of the last row of a frame.
REQ-019 brightness_ack  output  1  one-cycle pulse when a brightness reload completes.

Function
REQ-020 The block SHALL implement states IDLE, FETCH, CAPTURE, LOAD, SHIFT, LATCH, NEXT, BLOAD, BSHIFT, BLATCH; all outputs SHALL be registered.
REQ-021 IDLE: enable=1 SHALL go to BLOAD if brightness pending, else FETCH; enable=0 stays IDLE.
REQ-022 FETCH (1 cycle): mem_rd_en=1, mem_row_addr=row counter; next CAPTURE.
REQ-023 CAPTURE (1 cycle): row_colors<=frame_data, row_select<=row counter, pwm_time<=0; next LOAD.
REQ-024 LOAD (1 cycle): load_led_vals=1; next SHIFT.
REQ-025 SHIFT: shift=1 for exactly SHIFT_LEN consecutive cycles; next LATCH.
REQ-026 LATCH (1 cycle): panel_latch=1; if pwm_time==PWM_STEPS-1 go NEXT, else pwm_time+1 and go LOAD.
REQ-027 NEXT (1 cycle): row counter increments, wrapping ROWS-1 to 0; frame_done=1 on the wrap only.
REQ-028 From NEXT: enable=0 -> IDLE; wrapped row and brightness pending -> BLOAD; else FETCH.
REQ-029 BLOAD (1 cycle) load_brightness=1; BSHIFT shift=1 for SHIFT_LEN cycles; BLATCH (1 cycle) panel_latch=1, brightness_ack=1, pending cleared; next FETCH.
REQ-030 brightness_req SHALL set a sticky pending flag; a request coinciding with the BLATCH cycle SHALL leave pending set.
REQ-031 Deasserting enable mid-row SHALL NOT truncate the row; the block SHALL stop only at NEXT.
REQ-032 Row cycle count SHALL be 3 + PWM_STEPS*(SHIFT_LEN+2) cycles, FETCH through NEXT inclusive.
REQ-033 Strobes SHALL be mutually exclusive: at most one of load_led_vals, load_brightness, shift, panel_latch high per cycle.

Reset
REQ-034 On reset_n=0: state IDLE; row counter, row_select, mem_row_addr and pwm_time 0; row_colors all-zero; all strobes and pulses 0; brightness pending 0.
REQ-035 Reset asserted mid-operation SHALL abort immediately with no further strobes until enable is sampled in IDLE.

Verification
REQ-036 PWM_STEPS=4, enable=1 from reset: mem_rd_en at cycle 1, load_led_vals at cycles 3,21,39,57; 16 shift cycles after each; panel_latch at cycles 20,38,56,74; pwm_time steps 0..3.
REQ-037 ROWS=16, PWM_STEPS=4: frame_done pulses once every 1200 cycles; row_select sequence 0..15 then 0.
REQ-038 brightness_req pulsed during row 5: BLOAD follows the NEXT after row 15, 16 shifts, then panel_latch with brightness_ack; next FETCH addresses row 0.
REQ-039 enable dropped during the SHIFT of row 3: row 3 completes, NEXT moves row counter to 4, state IDLE, no further strobes.
REQ-040 reset_n pulsed low during SHIFT: all outputs 0 the same cycle; after release with enable=1, scan restarts with FETCH of row 0.
REQ-041 frame_data=0xA5 repeated, read at FETCH: row_colors equals frame_data from the CAPTURE cycle onward and holds through NEXT.
